// File: rtl/riscv_enc_pkg.sv
// Shared encodings for the instruction encoder: formats, opcodes, FSM states
// and the legal byte-offset range of each immediate format.
package riscv_enc_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int signed IMM12_MIN = -2048;
    localparam int signed IMM12_MAX = 2047;
    localparam int signed IMM13_MIN = -4096;
    localparam int signed IMM13_MAX = 4094;
    localparam int signed IMM21_MIN = -1048576;
    localparam int signed IMM21_MAX = 1048574;

    function automatic logic [6:0] opcode_of(input fmt_e fmt);
        logic [6:0] op;
        case (fmt)
            FMT_I:   op = OP_LOAD;
            FMT_S:   op = OP_STORE;
            FMT_B:   op = OP_BRANCH;
            default: op = OP_JAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I packer for I/S/B/J formats, with immediate range and
// alignment check.
module imm_pack
    import riscv_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic signed [31:0] imm_s;
    logic [6:0]         op;

    assign imm_s = signed'(imm_i);
    assign op    = opcode_of(fmt_i);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (fmt_i)
            FMT_I: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, op};
                legal_o = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_S: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op};
                legal_o = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_B: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], op};
                legal_o = (imm_s >= IMM13_MIN) && (imm_s <= IMM13_MAX) && !imm_i[0];
            end
            default: begin
                word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op};
                legal_o = (imm_s >= IMM21_MIN) && (imm_s <= IMM21_MAX) && !imm_i[0];
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field bundles into RV32I words and writes them to
// consecutive instruction-memory addresses through a one-entry output stage.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic              wrapped
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                mem_we_q;
    logic [31:0]         wdata_q;
    logic                done_q;
    logic [7:0]          err_q;
    logic                wrapped_q;

    logic                accept;
    logic                complete;
    logic [31:0]         pack_word;
    logic                pack_legal;

    imm_pack u_imm_pack (
        .fmt_i    (fmt_e'(in_fmt)),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .imm_i    (in_imm),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    // A new bundle may land in the output stage on the same edge the old word retires.
    assign in_ready = (state_q == ST_LOAD) && (!mem_we_q || mem_ready);
    assign accept   = in_valid && in_ready;
    assign complete = mem_we_q && mem_ready;
    assign addr_d   = addr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            mem_we_q  <= 1'b0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (complete) begin
                addr_q <= addr_d;
                if (addr_d == '0) begin
                    wrapped_q <= 1'b1;
                end
            end

            if (accept && pack_legal) begin
                mem_we_q <= 1'b1;
                wdata_q  <= pack_word;
            end else if (complete) begin
                mem_we_q <= 1'b0;
            end

            if (accept && !pack_legal && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        addr_q    <= base_addr;
                        err_q     <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && in_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!mem_we_q || mem_ready) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign wrapped   = wrapped_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader for the RISC-V core. It accepts decoded instruction fields (format, register indices, funct3, signed byte-offset immediate) over a valid/ready stream. It range-checks the immediate, packs the fields into a 32-bit RV32I word (I/S/B/J formats, the same set the core's immediate generator decodes), and writes the words to consecutive instruction-memory addresses through a one-entry output stage with backpressure. It sits between the test/boot host and instruction memory.

## Interface
- ADDR_W, 10, word-address width of the memory write port
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a load session at base_addr (honoured in IDLE only)
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready at clk edge
- in_fmt  in  2  00 I (opcode 0000011), 01 S (0100011), 10 B (1100011), 11 J (1101111)
- in_rd, in_rs1, in_rs2  in  5 each  register indices (unused fields ignored per format)
- in_funct3  in  3  funct3 (ignored for J)
- in_imm  in  32  signed byte offset
- in_last  in  1  final bundle of the session
- mem_we  out  1  write request; held until mem_ready
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session active (state != IDLE)
- done  out  1  one-cycle pulse at session end
- err_cnt  out  8  rejected-bundle count, saturates at 255, cleared on start
- wrapped  out  1  sticky; address counter wrapped this session, cleared on start

## Operation
- States: IDLE, LOAD, DRAIN. IDLE -> LOAD on start (addr <= base_addr, err_cnt/wrapped cleared). LOAD -> DRAIN on acceptance with in_last. DRAIN -> IDLE when output stage empty; done pulses in that transition cycle.
- start in LOAD/DRAIN ignored.
- in_ready = (state == LOAD) && (!mem_we || mem_ready).
- Packing: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Legal ranges: I/S -2048..2047; B -4096..4094, even; J -1048576..1048574, even. An out-of-range bundle is still accepted: no write, err_cnt++ (saturating), address unchanged.
- Address increments by 1 on each completed write (mem_we && mem_ready); wraps modulo 2^ADDR_W and sets wrapped.
- Rejected last bundle: DRAIN entered; done pulses once any pending write completes.

## Timing
- Reset: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err_cnt 0, wrapped 0, state IDLE. Reset mid-session drops mem_we at once and discards the pending word.
- Latency: bundle accepted at edge N -> mem_we/mem_addr/mem_wdata valid from N+1. Completion at first edge with mem_ready=1.
- Back-to-back: with mem_ready held 1, one write per cycle; completion and new acceptance may share an edge.
- mem_addr/mem_wdata stable while mem_we && !mem_ready.
- done: one cycle, registered; busy falls in the same cycle done rises.

## Structure
- Shared package riscv_enc_pkg: opcode constants, fmt encoding, state enum, immediate range limits.
- Sub-module imm_pack: combinational packer plus range/alignment checker (fmt, fields, imm -> word, legal). Top holds the FSM, the output register, and the counters.

## Test plan
- start base 0x010; I rd=5 rs1=2 f3=010 imm=-4 -> write 0xFFC12283 @0x010.
- S rs2=6 rs1=2 f3=010 imm=8, then B rs1=1 rs2=2 f3=000 imm=-8 -> 0x00612423 @0x011, 0xFE208CE3 @0x012, back-to-back.
- J rd=1 imm=2048 with in_last -> 0x001000EF written, done pulse next cycle after completion, busy 0.
- I imm=2048, then B imm=3 -> no writes, err_cnt=2, address unchanged; next legal bundle lands at the original address.
- mem_ready low 3 cycles -> mem_we/addr/data held, in_ready 0; write completes on 4th cycle.
- base 0x3FF, two legal bundles -> writes @0x3FF and @0x000, wrapped=1; assert rst while mem_we=1 -> all outputs reset values immediately.
